// File: rtl/dogx_sample_serializer.sv
// dogx_sample_serializer: buffers {alpha, sample} words from the converter
// in a small FIFO and streams each one MSB-first over N_LANES serial lanes.
//
// Ports:
//   CLK_24M          system clock
//   reset            synchronous active-high reset
//   sample_valid     capture strobe for converter_output/alpha_in
//   converter_output raw two's-complement sample
//   alpha_in         alpha range flag for the sample
//   clear_overflow   clears the sticky overflow flag
//   ser_data         serial lanes (0 whenever ser_active is low)
//   ser_frame        high on the first bit cycle of each word
//   ser_active       high on every bit cycle of a word
//   overflow         sticky flag: a sample was dropped
//   fifo_level       current FIFO occupancy
module dogx_sample_serializer #(
    parameter int DATA_W     = 11,
    parameter int N_LANES    = 2,
    parameter int GAP_CYCLES = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          CLK_24M,
    input  logic                          reset,
    input  logic                          sample_valid,
    input  logic [DATA_W-1:0]             converter_output,
    input  logic                          alpha_in,
    input  logic                          clear_overflow,
    output logic [N_LANES-1:0]            ser_data,
    output logic                          ser_frame,
    output logic                          ser_active,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int WORD_W = DATA_W + 1;
    localparam int BITS   = WORD_W / N_LANES;
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int LW     = AW + 1;
    localparam int MAXC   = (BITS > GAP_CYCLES) ? BITS : GAP_CYCLES;
    localparam int CW     = $clog2(MAXC) + 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [WORD_W-1:0]   shreg_q, shreg_d;
    logic [N_LANES-1:0]  data_q, data_d;
    logic                frame_q, frame_d;
    logic                active_q, active_d;
    logic                ovf_q, ovf_d;

    logic [WORD_W-1:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0]       wptr_q, wptr_d;
    logic [AW-1:0]       rptr_q, rptr_d;
    logic [LW-1:0]       count_q, count_d;

    logic [WORD_W-1:0]   word_in;
    logic [WORD_W-1:0]   head;
    logic                empty, full;
    logic                pop, load, do_push, drop;

    assign word_in = {alpha_in, converter_output};
    assign head    = mem_q[rptr_q];
    assign empty   = (count_q == '0);
    assign full    = (count_q == LW'(FIFO_DEPTH));

    // A pop frees a slot in the same edge, so a push into a full FIFO
    // only drops when nothing is leaving.
    assign drop    = sample_valid && full && !pop;
    assign do_push = sample_valid && !drop;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shreg_d  = shreg_q;
        data_d   = '0;
        frame_d  = 1'b0;
        active_d = 1'b0;
        load     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    load = 1'b1;
                end
            end
            SHIFT: begin
                if (cnt_q == CW'(BITS - 1)) begin
                    state_d = GAP;
                    cnt_d   = '0;
                end else begin
                    data_d   = shreg_q[WORD_W-1 -: N_LANES];
                    shreg_d  = shreg_q << N_LANES;
                    active_d = 1'b1;
                    cnt_d    = cnt_q + CW'(1);
                end
            end
            GAP: begin
                if (cnt_q == CW'(GAP_CYCLES - 1)) begin
                    if (!empty) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        // Loading drives bit cycle 0 straight into the output registers;
        // the shift register keeps the remaining bits.
        if (load) begin
            state_d  = SHIFT;
            cnt_d    = '0;
            data_d   = head[WORD_W-1 -: N_LANES];
            shreg_d  = head << N_LANES;
            frame_d  = 1'b1;
            active_d = 1'b1;
        end
    end

    assign pop = load;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_push) begin
            wptr_d = wptr_q + AW'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + AW'(1);
        end
        unique case ({do_push, pop})
            2'b10:   count_d = count_q + LW'(1);
            2'b01:   count_d = count_q - LW'(1);
            default: count_d = count_q;
        endcase
    end

    // Set wins over clear when both happen in one cycle.
    always_comb begin
        ovf_d = ovf_q;
        if (clear_overflow) begin
            ovf_d = 1'b0;
        end
        if (drop) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge CLK_24M) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            shreg_q  <= '0;
            data_q   <= '0;
            frame_q  <= 1'b0;
            active_q <= 1'b0;
            ovf_q    <= 1'b0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shreg_q  <= shreg_d;
            data_q   <= data_d;
            frame_q  <= frame_d;
            active_q <= active_d;
            ovf_q    <= ovf_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge CLK_24M) begin
        if (do_push && !reset) begin
            mem_q[wptr_q] <= word_in;
        end
    end

    assign ser_data   = data_q;
    assign ser_frame  = frame_q;
    assign ser_active = active_q;
    assign overflow   = ovf_q;
    assign fifo_level = count_q;

endmodule
